// File: rtl/ram_tp_fifo_ctrl.sv
// rtl/ram_tp_fifo_ctrl.sv - FIFO controller for an attached two-port RAM with registered read data
// Capacity is DEPTH words in RAM plus one word held in the RAM read-data register.
module ram_tp_fifo_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [DATA_WIDTH-1:0]          s_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [DATA_WIDTH-1:0]          m_data,
   output logic                           ram_cen,
   output logic                           ram_wen,
   output logic [$clog2(DEPTH)-1:0]       ram_waddr,
   output logic [DATA_WIDTH-1:0]          ram_wdata,
   output logic                           ram_ren,
   output logic [$clog2(DEPTH)-1:0]       ram_raddr,
   input  logic [DATA_WIDTH-1:0]          ram_rdata,
   output logic [$clog2(DEPTH+2)-1:0]     count
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int CNT_WIDTH  = $clog2(DEPTH+2);
   localparam logic [CNT_WIDTH-1:0]  FULL_CNT = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0]  ONE_CNT  = CNT_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ONE_PTR  = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CNT_WIDTH-1:0]  mem_cnt;
   logic                  push;
   logic                  rd_issue;
   logic                  pop;

   // mem_cnt excludes this cycle's write, so a word is never read in the cycle it lands
   assign s_ready  = (mem_cnt < FULL_CNT);
   assign push     = s_valid && s_ready && !reset;
   assign rd_issue = (mem_cnt != '0) && (!m_valid || m_ready) && !reset;
   assign pop      = m_valid && m_ready;

   assign ram_wen   = push;
   assign ram_waddr = wr_ptr;
   assign ram_wdata = s_data;
   assign ram_ren   = rd_issue;
   assign ram_raddr = rd_ptr;
   assign ram_cen   = push | rd_issue;
   assign m_data    = ram_rdata;
   assign count     = mem_cnt + {{(CNT_WIDTH-1){1'b0}}, m_valid};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         m_valid <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + ONE_PTR;
         if (rd_issue)
            rd_ptr <= rd_ptr + ONE_PTR;
         case ({push, rd_issue})
            2'b10:   mem_cnt <= mem_cnt + ONE_CNT;
            2'b01:   mem_cnt <= mem_cnt - ONE_CNT;
            default: mem_cnt <= mem_cnt;
         endcase
         // The read-data register refills whenever a read is issued, even as it is popped
         if (rd_issue)
            m_valid <= 1'b1;
         else if (pop)
            m_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ram_tp_fifo_ctrl.sv
// tb/tb_ram_tp_fifo_ctrl.sv - self-checking bench for ram_tp_fifo_ctrl with a behavioural two-port RAM
module tb_ram_tp_fifo_ctrl;
   localparam int DW = 8;
   localparam int DEPTH = 4;

   logic          clock;
   logic          reset;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          ram_cen;
   logic          ram_wen;
   logic [1:0]    ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic          ram_ren;
   logic [1:0]    ram_raddr;
   logic [DW-1:0] ram_rdata;
   logic [2:0]    count;

   logic [DW-1:0] mem [0:DEPTH-1];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   int total;
   int bad;

   ram_tp_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .count(count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         ram_rdata <= '0;
      end else begin
         if (ram_wen) mem[ram_waddr] <= ram_wdata;
         if (ram_ren) ram_rdata <= mem[ram_raddr];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog elapsed=200000 limit=200000");
      $fatal(1, "watchdog");
   end

   // Records this cycle's handshakes mid-cycle, then moves to 1 time unit after the next edge
   task automatic cycle();
      @(negedge clock);
      if (!reset && s_valid && s_ready) exp_q.push_back(s_data);
      if (!reset && m_valid && m_ready) got_q.push_back(m_data);
      @(posedge clock);
      #1;
   endtask

   task automatic flush();
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic drain(output bit ok);
      s_valid = 1'b0;
      m_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (count == 0 && exp_q.size() == got_q.size()) begin
            ok = 1'b1;
            break;
         end
         cycle();
      end
   endtask

   function automatic int order_errs();
      int e = 0;
      if (got_q.size() != exp_q.size()) e++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) e++;
      return e;
   endfunction

   task automatic test_reset();
      reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      #2 reset = 1'b1;
      s_valid = 1'b1; s_data = 8'h55;
      @(posedge clock); @(posedge clock); #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      total++; if ({ram_wen, ram_ren, ram_cen} !== 3'b000) begin bad++; $display("FAIL reset_ram got=%b exp=000", {ram_wen, ram_ren, ram_cen}); end
      reset = 1'b0;
      s_valid = 1'b0;
      cycle();
      flush();
   endtask

   task automatic test_single();
      bit ok;
      s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
      #1;
      total++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0) begin bad++; $display("FAIL single_c0 got wen=%b ren=%b exp wen=1 ren=0", ram_wen, ram_ren); end
      cycle();
      s_valid = 1'b0;
      #1;
      total++; if (ram_ren !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL single_c1 got ren=%b mv=%b exp ren=1 mv=0", ram_ren, m_valid); end
      cycle();
      total++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin bad++; $display("FAIL single_c2 got mv=%b data=%0h exp mv=1 data=a5", m_valid, m_data); end
      cycle();
      total++; if (count !== 3'd0 || m_valid !== 1'b0) begin bad++; $display("FAIL single_c3 got count=%0d mv=%b exp count=0 mv=0", count, m_valid); end
      drain(ok);
      total++; if (!ok || order_errs() != 0) begin bad++; $display("FAIL single_order got errs=%0d ok=%b exp errs=0 ok=1", order_errs(), ok); end
      flush();
   endtask

   task automatic test_fill();
      bit ok;
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1;
         s_data = (exp_q.size() < 5) ? 8'(exp_q.size() + 1) : 8'h06;
         #1;
         if (count == 3'd5) begin
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", s_ready); end
         end
         cycle();
      end
      total++; if (exp_q.size() != 5) begin bad++; $display("FAIL fill_accepted got=%0d exp=5", exp_q.size()); end
      total++; if (count !== 3'd5 || s_ready !== 1'b0) begin bad++; $display("FAIL fill_state got count=%0d ready=%b exp count=5 ready=0", count, s_ready); end
      drain(ok);
      total++; if (!ok || order_errs() != 0) begin bad++; $display("FAIL fill_order got errs=%0d ok=%b exp errs=0 ok=1", order_errs(), ok); end
      total++; if (got_q.size() != 5 || got_q[0] !== 8'h01 || got_q[got_q.size()-1] !== 8'h05) begin bad++; $display("FAIL fill_values got n=%0d exp n=5 first=01 last=05", got_q.size()); end
      flush();
   endtask

   task automatic test_stream();
      bit ok;
      m_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         s_valid = (i < 20);
         s_data = 8'(i);
         #1;
         if (i < 20) begin
            total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL stream_ready cyc=%0d got=%b exp=1", i, s_ready); end
         end
         if (i >= 2 && i <= 21) begin
            total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL stream_nostall cyc=%0d got=%b exp=1", i, m_valid); end
         end
         cycle();
      end
      drain(ok);
      total++; if (!ok || got_q.size() != 20 || order_errs() != 0) begin bad++; $display("FAIL stream_order got n=%0d errs=%0d exp n=20 errs=0", got_q.size(), order_errs()); end
      flush();
   endtask

   task automatic test_backpressure();
      bit ok;
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = 8'h30 + 8'(i);
         cycle();
      end
      s_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (m_valid !== 1'b1 || m_data !== 8'h30 || ram_ren !== 1'b0) begin bad++; $display("FAIL bp_hold cyc=%0d got mv=%b data=%0h ren=%b exp mv=1 data=30 ren=0", i, m_valid, m_data, ram_ren); end
         cycle();
      end
      drain(ok);
      total++; if (!ok || order_errs() != 0) begin bad++; $display("FAIL bp_order got errs=%0d ok=%b exp errs=0 ok=1", order_errs(), ok); end
      flush();
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = 8'h40 + 8'(i);
         cycle();
      end
      s_valid = 1'b0;
      #1;
      total++; if (count !== 3'd3) begin bad++; $display("FAIL rst_mid_pre got=%0d exp=3", count); end
      reset = 1'b1;
      s_valid = 1'b1;
      #1;
      total++; if (count !== 3'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_async got count=%0d mv=%b ready=%b exp 0 0 1", count, m_valid, s_ready); end
      total++; if (ram_wen !== 1'b0 || ram_ren !== 1'b0 || ram_cen !== 1'b0) begin bad++; $display("FAIL rst_mid_ram got %b%b%b exp 000", ram_wen, ram_ren, ram_cen); end
      cycle();
      reset = 1'b0;
      s_valid = 1'b0;
      flush();
      s_valid = 1'b1; s_data = 8'h7E; m_ready = 1'b1;
      cycle();
      s_valid = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      total++; if (got_q.size() != 1 || got_q[0] !== 8'h7E) begin bad++; $display("FAIL rst_mid_after got n=%0d exp n=1 data=7e", got_q.size()); end
      flush();
   endtask

   task automatic test_full_pop();
      bit ok;
      m_ready = 1'b0;
      for (int i = 0; i < 20 && count != 3'd5; i++) begin
         s_valid = 1'b1;
         s_data = 8'(exp_q.size() + 1);
         cycle();
      end
      s_valid = 1'b1; s_data = 8'h06;
      #1;
      total++; if (count !== 3'd5) begin bad++; $display("FAIL fullpop_fill got=%0d exp=5", count); end
      m_ready = 1'b1;
      #1;
      total++; if (s_ready !== 1'b0 || ram_ren !== 1'b1) begin bad++; $display("FAIL fullpop_issue got ready=%b ren=%b exp ready=0 ren=1", s_ready, ram_ren); end
      cycle();
      total++; if (s_ready !== 1'b1 || ram_wen !== 1'b1) begin bad++; $display("FAIL fullpop_accept got ready=%b wen=%b exp ready=1 wen=1", s_ready, ram_wen); end
      cycle();
      drain(ok);
      total++; if (!ok || exp_q.size() != 6 || order_errs() != 0) begin bad++; $display("FAIL fullpop_order got n=%0d errs=%0d exp n=6 errs=0", exp_q.size(), order_errs()); end
      flush();
   endtask

   task automatic test_random();
      bit ok;
      bit hold;
      logic [DW-1:0] hold_data;
      int occ;
      hold = 1'b0;
      hold_data = '0;
      for (int i = 0; i < 300; i++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_data = 8'($urandom);
         m_ready = ($urandom_range(0, 2) != 0);
         #1;
         occ = exp_q.size() - got_q.size();
         total++; if (count !== 3'(occ)) begin bad++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, count, occ); end
         total++; if (ram_cen !== (ram_wen | ram_ren)) begin bad++; $display("FAIL rand_cen cyc=%0d got=%b exp=%b", i, ram_cen, ram_wen | ram_ren); end
         if (occ <= DEPTH - 1) begin
            total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=1", i, s_ready); end
         end
         if (occ == DEPTH + 1) begin
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rand_full cyc=%0d got=%b exp=0", i, s_ready); end
         end
         if (occ == 0) begin
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rand_empty cyc=%0d got=%b exp=0", i, m_valid); end
         end
         if (hold) begin
            total++; if (m_valid !== 1'b1 || m_data !== hold_data) begin bad++; $display("FAIL rand_stable cyc=%0d got mv=%b data=%0h exp mv=1 data=%0h", i, m_valid, m_data, hold_data); end
         end
         if (m_valid === 1'b1 && m_ready === 1'b0) begin
            total++; if (ram_ren !== 1'b0) begin bad++; $display("FAIL rand_ren_bp cyc=%0d got=%b exp=0", i, ram_ren); end
         end
         hold = (m_valid === 1'b1 && m_ready === 1'b0);
         hold_data = m_data;
         cycle();
      end
      drain(ok);
      total++; if (!ok || order_errs() != 0) begin bad++; $display("FAIL rand_order got errs=%0d ok=%b exp errs=0 ok=1", order_errs(), ok); end
      flush();
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_backpressure();
      test_reset_mid();
      test_full_pop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
